// File: rtl/tx_sched.sv
// tx_sched: frames ADC sample bursts and single status words for the nibble transmitter.
// Optional status path and round-robin arbiter are built when TXSCHED_STAT_EN is defined.
module tx_sched #(
  parameter int BURST = 32,
  parameter int IFG   = 12
) (
  input  logic        clk125,
  input  logic        reset,
  input  logic        fifo_afull,
  input  logic [39:0] fifo_q,
  output logic        fifo_rden,
  input  logic        stat_req,
  input  logic [39:0] stat_data,
  output logic        stat_ack,
  input  logic        word_req,
  output logic        tx_valid,
  output logic [39:0] tx_data,
  output logic        tx_sof,
  output logic        tx_eof,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ADC, STAT, GAP} state_t;

  localparam logic [7:0] BURST_LEN = 8'(BURST);
  localparam logic [7:0] LAST_WORD = 8'(BURST - 1);
  localparam logic [7:0] GAP_LOAD  = 8'(IFG - 1);

  state_t      state_reg, state_next;
  logic [7:0]  issue_cnt_reg, word_cnt_reg, gap_cnt_reg;
  logic        rden_reg, valid_reg;
  logic        adc_accept, adc_emit, adc_last, adc_enter;
  logic        grant_adc, grant_stat, stat_pulse;
  logic [39:0] stat_word;

  // issue_cnt caps accepted reads at BURST; word_cnt tracks words actually delivered
  assign adc_accept = (state_reg == ADC) && word_req && (issue_cnt_reg != BURST_LEN);
  assign adc_emit   = (state_reg == ADC) && valid_reg;
  assign adc_last   = adc_emit && (word_cnt_reg == LAST_WORD);
  assign adc_enter  = (state_reg == IDLE) && grant_adc;

`ifdef TXSCHED_STAT_EN
  logic stat_pulse_reg, last_adc_reg;

  // On a tie the source not granted last time wins
  assign grant_adc  = fifo_afull && !(stat_req && last_adc_reg);
  assign grant_stat = stat_req && !grant_adc;
  assign stat_pulse = stat_pulse_reg;
  assign stat_word  = stat_data;

  always_ff @(posedge clk125) begin
    if (reset) begin
      stat_pulse_reg <= 1'b0;
      last_adc_reg   <= 1'b0;
    end else begin
      stat_pulse_reg <= (state_reg == STAT) && word_req && !stat_pulse_reg;
      if ((state_reg == IDLE) && (grant_adc || grant_stat))
        last_adc_reg <= grant_adc;
    end
  end
`else
  logic unused_stat;

  assign unused_stat = ^{stat_req, stat_data};
  assign grant_adc   = fifo_afull;
  assign grant_stat  = 1'b0;
  assign stat_pulse  = 1'b0;
  assign stat_word   = '0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (grant_adc)
          state_next = ADC;
        else if (grant_stat)
          state_next = STAT;
      end
      ADC:  if (adc_last) state_next = GAP;
      STAT: if (stat_pulse) state_next = GAP;
      GAP:  if (gap_cnt_reg == 8'd0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk125) begin
    if (reset) begin
      state_reg     <= IDLE;
      issue_cnt_reg <= 8'd0;
      word_cnt_reg  <= 8'd0;
      gap_cnt_reg   <= 8'd0;
      rden_reg      <= 1'b0;
      valid_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      rden_reg  <= adc_accept;
      valid_reg <= rden_reg;
      if (adc_enter) begin
        issue_cnt_reg <= 8'd0;
        word_cnt_reg  <= 8'd0;
      end else begin
        if (adc_accept)
          issue_cnt_reg <= issue_cnt_reg + 8'd1;
        if (adc_emit)
          word_cnt_reg <= word_cnt_reg + 8'd1;
      end
      if ((state_next == GAP) && (state_reg != GAP))
        gap_cnt_reg <= GAP_LOAD;
      else if ((state_reg == GAP) && (gap_cnt_reg != 8'd0))
        gap_cnt_reg <= gap_cnt_reg - 8'd1;
    end
  end

  // fifo_q is passed straight through so data lands exactly two cycles after word_req
  always_comb begin
    fifo_rden = rden_reg;
    stat_ack  = stat_pulse;
    tx_valid  = adc_emit || stat_pulse;
    tx_sof    = (adc_emit && (word_cnt_reg == 8'd0)) || stat_pulse;
    tx_eof    = adc_last || stat_pulse;
    busy      = (state_reg != IDLE);
    tx_data   = '0;
    if (adc_emit)
      tx_data = fifo_q;
    else if (stat_pulse)
      tx_data = stat_word;
    if (reset) begin
      fifo_rden = 1'b0;
      stat_ack  = 1'b0;
      tx_valid  = 1'b0;
      tx_sof    = 1'b0;
      tx_eof    = 1'b0;
      busy      = 1'b0;
      tx_data   = '0;
    end
  end

endmodule

// File: tb/tb_tx_sched.sv
// tb_tx_sched: randomized stimulus against a frame-level reference model of tx_sched.
// Follows TXSCHED_STAT_EN so the same bench covers both builds.
module tb_tx_sched;
  localparam int BURST = 32;
  localparam int IFG   = 12;
`ifdef TXSCHED_STAT_EN
  localparam bit STAT_EN = 1'b1;
`else
  localparam bit STAT_EN = 1'b0;
`endif

  logic        clk125 = 1'b0;
  logic        reset, fifo_afull, fifo_rden, stat_req, stat_ack, word_req;
  logic        tx_valid, tx_sof, tx_eof, busy;
  logic [39:0] fifo_q, stat_data, tx_data;

  tx_sched #(.BURST(BURST), .IFG(IFG)) dut (
    .clk125(clk125), .reset(reset), .fifo_afull(fifo_afull), .fifo_q(fifo_q),
    .fifo_rden(fifo_rden), .stat_req(stat_req), .stat_data(stat_data),
    .stat_ack(stat_ack), .word_req(word_req), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_sof(tx_sof), .tx_eof(tx_eof), .busy(busy)
  );

  always #4 clk125 = ~clk125;

  typedef enum {M_IDLE, M_ADC, M_STAT, M_GAP} mode_t;

  mode_t       mode;
  int          checks, failures, cyc;
  int          accepted, emitted, gap_left, rd_issued, fifo_rd;
  bit          last_adc, stat_fired, frame_done, after_reset;
  int          pend_cyc[$];
  int          pend_idx[$];
  logic [39:0] fifo_mem [4096];
  logic        e_rden, e_valid, e_sof, e_eof, e_ack, e_busy, e_data_chk;
  logic [39:0] e_data;

  task automatic check_eq(input string tag, input logic [39:0] got, input logic [39:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [39:0] rand40();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[39:0];
  endfunction

  // Expected outputs for the cycle just after the current clock edge
  task automatic model_step();
    mode_t nm;
    int    idx;
    {e_rden, e_valid, e_sof, e_eof, e_ack, e_busy} = '0;
    e_data     = '0;
    e_data_chk = after_reset;
    after_reset = 1'b0;
    if (reset) begin
      mode = M_IDLE;
      accepted = 0; emitted = 0; gap_left = 0;
      last_adc = 1'b0; stat_fired = 1'b0; frame_done = 1'b0;
      pend_cyc.delete();
      pend_idx.delete();
      e_data_chk  = 1'b1;
      after_reset = 1'b1;
      return;
    end
    nm = mode;
    case (mode)
      M_IDLE: begin
        if (fifo_afull && STAT_EN && stat_req)
          nm = last_adc ? M_STAT : M_ADC;
        else if (STAT_EN && stat_req)
          nm = M_STAT;
        else if (fifo_afull)
          nm = M_ADC;
        if (nm == M_ADC) begin
          accepted = 0; emitted = 0; frame_done = 1'b0; last_adc = 1'b1;
        end else if (nm == M_STAT) begin
          stat_fired = 1'b0; last_adc = 1'b0;
        end
      end
      M_ADC: begin
        if (frame_done) begin
          nm = M_GAP;
          gap_left = IFG;
        end else if (word_req && accepted < BURST) begin
          accepted++;
          e_rden = 1'b1;
          pend_cyc.push_back(cyc + 1);
          pend_idx.push_back(rd_issued);
          rd_issued++;
        end
      end
      M_STAT: begin
        if (stat_fired) begin
          nm = M_GAP;
          gap_left = IFG;
        end else if (word_req) begin
          stat_fired = 1'b1;
          {e_valid, e_sof, e_eof, e_ack, e_data_chk} = 5'b11111;
          e_data = stat_data;
        end
      end
      M_GAP: begin
        gap_left--;
        if (gap_left == 0) nm = M_IDLE;
      end
      default: nm = M_IDLE;
    endcase
    if (pend_cyc.size() > 0 && pend_cyc[0] == cyc) begin
      void'(pend_cyc.pop_front());
      idx = pend_idx.pop_front();
      e_valid    = 1'b1;
      e_sof      = (emitted == 0);
      e_eof      = (emitted == BURST - 1);
      e_data     = fifo_mem[idx % 4096];
      e_data_chk = 1'b1;
      emitted++;
      if (emitted == BURST) frame_done = 1'b1;
    end
    mode   = nm;
    e_busy = (mode != M_IDLE);
  endtask

  task automatic compare();
    check_eq("fifo_rden", {39'd0, fifo_rden}, {39'd0, e_rden});
    check_eq("tx_valid",  {39'd0, tx_valid},  {39'd0, e_valid});
    check_eq("tx_sof",    {39'd0, tx_sof},    {39'd0, e_sof});
    check_eq("tx_eof",    {39'd0, tx_eof},    {39'd0, e_eof});
    check_eq("stat_ack",  {39'd0, stat_ack},  {39'd0, e_ack});
    check_eq("busy",      {39'd0, busy},      {39'd0, e_busy});
    if (e_data_chk)
      check_eq("tx_data", tx_data, e_data);
    if (tx_valid)
      $display("tx cyc=%0d data=%h sof=%b eof=%b ack=%b", cyc, tx_data, tx_sof, tx_eof, stat_ack);
  endtask

  // One clock: check outputs after the edge, then act as the sample FIFO
  task automatic tick();
    @(negedge clk125);
    cyc++;
    model_step();
    compare();
    if (fifo_rden) begin
      fifo_q = fifo_mem[fifo_rd % 4096];
      fifo_rd++;
    end
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0; rd_issued = 0; fifo_rd = 0;
    mode = M_IDLE; accepted = 0; emitted = 0; gap_left = 0;
    last_adc = 1'b0; stat_fired = 1'b0; frame_done = 1'b0; after_reset = 1'b0;
    for (int i = 0; i < 4096; i++) fifo_mem[i] = rand40();
    reset = 1'b1; fifo_afull = 1'b0; fifo_q = '0; stat_req = 1'b0;
    stat_data = '0; word_req = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b0;

    // Full ADC frames at a slow word rate, including the inter-frame gap
    fifo_afull = 1'b1;
    for (int i = 0; i < 720; i++) begin
      word_req = (i % 10 == 0);
      tick();
    end

    // Back-to-back word requests
    for (int i = 0; i < 200; i++) begin
      word_req = 1'b1;
      tick();
    end

    // Single status word with a fixed pattern
    fifo_afull = 1'b0; stat_req = 1'b1; stat_data = 40'h12_3456_789A;
    for (int i = 0; i < 150; i++) begin
      word_req = (i % 3 == 0);
      tick();
      if (stat_ack) stat_req = 1'b0;
    end

    // Both sources pending: frames must alternate
    fifo_afull = 1'b1;
    for (int i = 0; i < 900; i++) begin
      word_req = ($urandom_range(0, 3) != 0);
      tick();
      if (stat_ack) stat_req = 1'b0;
      else if (!stat_req) begin
        stat_req = 1'b1;
        stat_data = rand40();
      end
    end

    // Reset in the middle of an ADC frame at word 10
    stat_req = 1'b0; fifo_afull = 1'b1;
    for (int i = 0; i < 3000 && !(mode == M_ADC && emitted == 10); i++) begin
      word_req = $urandom_range(0, 1);
      tick();
    end
    check_eq("reach_word10", 40'(emitted), 40'd10);
    reset = 1'b1; word_req = 1'b0;
    tick();
    reset = 1'b0; fifo_afull = 1'b0;
    tick();
    tick();
    fifo_afull = 1'b1;
    for (int i = 0; i < 300; i++) begin
      word_req = $urandom_range(0, 1);
      tick();
    end

    // Status request alone, FIFO never almost-full
    fifo_afull = 1'b0; stat_req = 1'b1; stat_data = rand40();
    for (int i = 0; i < 1000; i++) begin
      word_req = ($urandom_range(0, 4) == 0);
      tick();
      if (stat_ack) stat_req = 1'b0;
    end

    // Fully random traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      word_req   = $urandom_range(0, 1);
      fifo_afull = ($urandom_range(0, 3) != 0);
      reset      = ($urandom_range(0, 199) == 0);
      tick();
      if (stat_ack) stat_req = 1'b0;
      else if (!stat_req && $urandom_range(0, 7) == 0) begin
        stat_req = 1'b1;
        stat_data = rand40();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tx_sched.md
TX_SCHED -- requirements
Module: tx_sched

Interface
REQ-001 Parameter BURST, default 32, words per frame (range 2..255).
REQ-002 Parameter IFG, default 12, idle clk125 cycles between frames (range 1..255).
REQ-003 clk125 input 1: sole clock; all logic on its rising edge.
REQ-004 reset input 1: synchronous, active-high.
REQ-005 fifo_afull input 1: sample FIFO Almost_Full.
REQ-006 fifo_q input 40: sample FIFO Q, valid the cycle after fifo_rden.
REQ-007 fifo_rden output 1: sample FIFO read enable.
REQ-008 stat_req input 1: status word pending, level, held until stat_ack.
REQ-009 stat_data input 40: status word, stable while stat_req is high.
REQ-010 stat_ack output 1: one-cycle pulse when stat_data is taken.
REQ-011 word_req input 1: one-cycle pulse from the nibble transmitter requesting the next word.
REQ-012 tx_valid output 1: one-cycle pulse, tx_data valid.
REQ-013 tx_data output 40: word to transmitter.
REQ-014 tx_sof / tx_eof output 1 each: qualify first / last word of a frame, only with tx_valid.
REQ-015 busy output 1: high in any state except IDLE.

Function
REQ-016 FSM states: IDLE, ADC, STAT, GAP.
REQ-017 IDLE: stat_req and fifo_afull both high -> source opposite to last granted (round-robin; after reset, ADC); else stat_req -> STAT; else fifo_afull -> ADC; else stay.
REQ-018 ADC: each word_req drives fifo_rden high exactly 1 cycle later; tx_valid with tx_data=fifo_q exactly 2 cycles after word_req.
REQ-019 ADC: 8-bit word counter increments per tx_valid; tx_sof on word 0, tx_eof on word BURST-1; after the eof word -> GAP.
REQ-020 STAT: first word_req -> tx_valid, tx_sof, tx_eof, tx_data=stat_data, stat_ack all high 1 cycle later; then -> GAP.
REQ-021 GAP: counter loads IFG-1 on entry, decrements per cycle, -> IDLE when at 0; word_req in GAP or IDLE ignored, no tx_valid.
REQ-022 word_req arriving while a prior read is in flight (back-to-back pulses) accepted; pipeline depth 2, every accepted word_req yields exactly one tx_valid.
REQ-023 fifo_afull deasserting mid-frame does not abort; frame always completes BURST words.
REQ-024 stat_req asserting mid-ADC-frame waits until next IDLE arbitration.
REQ-025 fifo_rden never asserted outside ADC; stat_ack never asserted outside STAT.
REQ-026 Word counter and grant history wrap-free: counter cleared on each ADC entry.

Reset
REQ-027 reset high: state IDLE, all counters 0, last-grant = STAT (so ADC wins first tie), in-flight pipeline flushed.
REQ-028 Outputs during and on the cycle after reset: fifo_rden, stat_ack, tx_valid, tx_sof, tx_eof, busy = 0; tx_data = 0.
REQ-029 reset mid-frame: frame truncated, no tx_eof, no pending tx_valid emitted.

Configuration
REQ-030 Macro TXSCHED_STAT_EN: defined -> status path and round-robin as above.
REQ-031 Not defined: STAT state and arbiter removed, stat_ack tied 0, stat_req/stat_data ignored, IDLE -> ADC on fifo_afull only.

Verification
REQ-032 fifo_afull=1, word_req every 10 cycles, BURST=32 -> 32 tx_valid, sof on 1st, eof on 32nd, fifo_rden 1 cycle after each word_req, then exactly 12 idle cycles before next sof.
REQ-033 stat_req=1, stat_data=40'h12_3456_789A, fifo_afull=0, word_req -> tx_data=40'h12_3456_789A, sof=eof=stat_ack=1, single pulse.
REQ-034 stat_req and fifo_afull held high -> frames alternate ADC, STAT, ADC, STAT; first is ADC.
REQ-035 reset pulsed at word 10 of ADC frame -> no eof, all outputs 0 next cycle, next frame starts with sof and counter 0.
REQ-036 TXSCHED_STAT_EN undefined, stat_req=1, fifo_afull=0 for 1000 cycles -> stat_ack, tx_valid, busy stay 0.
REQ-037 word_req on consecutive cycles -> tx_valid on consecutive cycles, 2-cycle latency, tx_data equals fifo_q sequence in order.
